// File: rtl/ring_router_mux_arb.sv
// Packet-atomic arbiter for a debug-ring router output link.
// Ring through-traffic has priority; a starvation counter forces local injection after MAX_RING_PKTS ring packets.
module ring_router_mux_arb #(
    parameter int MAX_RING_PKTS = 4,
    parameter int CNT_W         = $clog2(MAX_RING_PKTS + 1),
    parameter int DATA_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [DATA_W-1:0] in_ring_data,
    input  logic              in_ring_last,
    input  logic              in_ring_valid,
    output logic              in_ring_ready,

    input  logic [DATA_W-1:0] in_local_data,
    input  logic              in_local_last,
    input  logic              in_local_valid,
    output logic              in_local_ready,

    output logic [DATA_W-1:0] out_ring_data,
    output logic              out_ring_last,
    output logic              out_ring_valid,
    input  logic              out_ring_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RING  = 2'd1,
        LOCAL = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE  = 2'd0,
        SEL_RING  = 2'd1,
        SEL_LOCAL = 2'd2
    } sel_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_RING_PKTS);

    state_t           state;
    state_t           state_nxt;
    sel_t             sel;
    logic             grant;
    logic             hs;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Source selection: arbitrate only in IDLE, otherwise the worm owner keeps the link.
    always_comb begin
        sel = SEL_NONE;
        case (state)
            IDLE: begin
                if (in_ring_valid && in_local_valid)
                    sel = (cnt >= CNT_MAX) ? SEL_LOCAL : SEL_RING;
                else if (in_ring_valid)
                    sel = SEL_RING;
                else if (in_local_valid)
                    sel = SEL_LOCAL;
            end
            RING:    sel = SEL_RING;
            LOCAL:   sel = SEL_LOCAL;
            default: sel = SEL_NONE;
        endcase
    end

    assign grant = (state == IDLE) && (sel != SEL_NONE);
    assign hs    = out_ring_valid && out_ring_ready;

    // A stalled grant moves into the owner state so it cannot be stolen next cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant && !(hs && out_ring_last))
                    state_nxt = (sel == SEL_RING) ? RING : LOCAL;
            end
            RING, LOCAL: begin
                if (hs && out_ring_last)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt = cnt;
        if (grant) begin
            if (sel == SEL_RING && in_local_valid)
                cnt_nxt = (cnt >= CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
            else
                cnt_nxt = '0;
        end
    end

    always_comb begin
        out_ring_data  = '0;
        out_ring_last  = 1'b0;
        out_ring_valid = 1'b0;
        in_ring_ready  = 1'b0;
        in_local_ready = 1'b0;
        case (sel)
            SEL_RING: begin
                out_ring_data  = in_ring_data;
                out_ring_last  = in_ring_last;
                out_ring_valid = in_ring_valid;
                in_ring_ready  = out_ring_ready;
            end
            SEL_LOCAL: begin
                out_ring_data  = in_local_data;
                out_ring_last  = in_local_last;
                out_ring_valid = in_local_valid;
                in_local_ready = out_ring_ready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ring_router_mux_arb.sv
// Randomized and directed bench for ring_router_mux_arb with a packet-level arbitration model and scoreboard.
module tb_ring_router_mux_arb;

    localparam int MAX = 4;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } flit_t;

    typedef struct packed {
        logic        src;
        logic [15:0] data;
        logic        last;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_ring_data = '0;
    logic        in_ring_last = 1'b0;
    logic        in_ring_valid = 1'b0;
    logic        in_ring_ready;
    logic [15:0] in_local_data = '0;
    logic        in_local_last = 1'b0;
    logic        in_local_valid = 1'b0;
    logic        in_local_ready;
    logic [15:0] out_ring_data;
    logic        out_ring_last;
    logic        out_ring_valid;
    logic        out_ring_ready = 1'b0;

    ring_router_mux_arb #(.MAX_RING_PKTS(MAX)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_ring_data   (in_ring_data),
        .in_ring_last   (in_ring_last),
        .in_ring_valid  (in_ring_valid),
        .in_ring_ready  (in_ring_ready),
        .in_local_data  (in_local_data),
        .in_local_last  (in_local_last),
        .in_local_valid (in_local_valid),
        .in_local_ready (in_local_ready),
        .out_ring_data  (out_ring_data),
        .out_ring_last  (out_ring_last),
        .out_ring_valid (out_ring_valid),
        .out_ring_ready (out_ring_ready)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail   = 0;

    flit_t rq[$];
    flit_t lq[$];
    sb_t   exp_q[$];
    int    pkt_order[$];

    bit    r_pres, l_pres, r_en, l_en, mon_en;
    int    pres_pct = 100;
    int    rdy_pct  = 100;

    // Reference model: which packet holds the link and how many ring packets in a row overtook a waiting local one.
    int    owner  = -1;
    int    streak = 0;
    bit    exp_v, exp_rr, exp_lr, exp_last;
    logic [15:0] exp_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic add_pkt(input bit src, input int len, input logic [15:0] base);
        flit_t f;
        for (int i = 0; i < len; i++) begin
            f.data = base + 16'(i);
            f.last = (i == len - 1);
            if (src) lq.push_back(f);
            else     rq.push_back(f);
        end
    endtask

    task automatic model_step();
        int    s;
        bit    grant;
        bit    v;
        flit_t f;
        sb_t   e;
        grant = 1'b0;
        f     = '0;
        if (owner < 0) begin
            if (r_pres && l_pres) s = (streak >= MAX) ? 1 : 0;
            else if (r_pres)      s = 0;
            else if (l_pres)      s = 1;
            else                  s = -1;
            grant = (s >= 0);
            if (grant) streak = (s == 0 && l_pres) ? ((streak + 1 > MAX) ? MAX : streak + 1) : 0;
        end else begin
            s = owner;
        end
        v = 1'b0;
        if (s == 0 && r_pres) begin v = 1'b1; f = rq[0]; end
        if (s == 1 && l_pres) begin v = 1'b1; f = lq[0]; end
        exp_v    = v;
        exp_rr   = (s == 0) && out_ring_ready;
        exp_lr   = (s == 1) && out_ring_ready;
        exp_data = f.data;
        exp_last = f.last;
        if (v && out_ring_ready) begin
            e.src  = (s == 1);
            e.data = f.data;
            e.last = f.last;
            exp_q.push_back(e);
            if (f.last) owner = -1;
            else if (grant) owner = s;
        end else if (grant) begin
            owner = s;
        end
    endtask

    // One clock cycle starting just after a rising edge; rdy < 0 means random backpressure.
    task automatic cycle(input int rdy);
        bit r_acc, l_acc;
        if (!r_pres && r_en && rq.size() > 0 && $urandom_range(99) < pres_pct) r_pres = 1'b1;
        if (!l_pres && l_en && lq.size() > 0 && $urandom_range(99) < pres_pct) l_pres = 1'b1;
        in_ring_valid  = r_pres;
        in_ring_data   = r_pres ? rq[0].data : 16'h0;
        in_ring_last   = r_pres ? rq[0].last : 1'b0;
        in_local_valid = l_pres;
        in_local_data  = l_pres ? lq[0].data : 16'h0;
        in_local_last  = l_pres ? lq[0].last : 1'b0;
        out_ring_ready = (rdy < 0) ? ($urandom_range(99) < rdy_pct) : (rdy != 0);
        model_step();
        #1;
        r_acc = r_pres && in_ring_ready;
        l_acc = l_pres && in_local_ready;
        @(posedge clk);
        #1;
        if (r_acc) begin void'(rq.pop_front()); r_pres = 1'b0; end
        if (l_acc) begin void'(lq.pop_front()); l_pres = 1'b0; end
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst_n  = 1'b0;
        in_ring_valid = 1'b0;  in_ring_data = '0;  in_ring_last = 1'b0;
        in_local_valid = 1'b0; in_local_data = '0; in_local_last = 1'b0;
        out_ring_ready = 1'b0;
        r_pres = 1'b0; l_pres = 1'b0; r_en = 1'b1; l_en = 1'b1;
        rq.delete(); lq.delete(); exp_q.delete(); pkt_order.delete();
        owner = -1; streak = 0;
        exp_v = 1'b0; exp_rr = 1'b0; exp_lr = 1'b0;
        #1;
        check("rst_out_valid", out_ring_valid, 0);
        check("rst_ring_ready", in_ring_ready, 0);
        check("rst_local_ready", in_local_ready, 0);
        @(posedge clk); #1;
        out_ring_ready = 1'b1;
        #1;
        check("rst_ready_idle", {in_ring_ready, in_local_ready, out_ring_valid}, 0);
        out_ring_ready = 1'b0;
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic drain(input int budget, input int rdy);
        int n = 0;
        while ((rq.size() > 0 || lq.size() > 0) && n < budget) begin
            cycle(rdy);
            n++;
        end
        n_checks++;
        if (rq.size() > 0 || lq.size() > 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d ring and %0d local flits left, required 0", rq.size(), lq.size());
        end
        check("sb_empty", exp_q.size(), 0);
    endtask

    task automatic check_order(input string name, input int expv[]);
        n_checks++;
        if (pkt_order.size() < expv.size()) begin
            n_fail++;
            $display("FAIL %s: got %0d packets, required at least %0d", name, pkt_order.size(), expv.size());
        end else begin
            for (int i = 0; i < expv.size(); i++) check(name, pkt_order[i], expv[i]);
        end
    endtask

    // Monitor: per-cycle output expectations plus the handshake scoreboard.
    sb_t e_mon;
    always @(negedge clk) begin
        if (mon_en) begin
            check("out_valid", out_ring_valid, exp_v);
            check("ring_ready", in_ring_ready, exp_rr);
            check("local_ready", in_local_ready, exp_lr);
            if (exp_v) begin
                check("out_data", out_ring_data, exp_data);
                check("out_last", out_ring_last, exp_last);
            end
            if (out_ring_valid && out_ring_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: unexpected flit 0x%0h, required none", out_ring_data);
                end else begin
                    e_mon = exp_q.pop_front();
                    check("sb_src", in_local_ready, e_mon.src);
                    check("sb_data", out_ring_data, e_mon.data);
                    check("sb_last", out_ring_last, e_mon.last);
                end
                if (out_ring_last) pkt_order.push_back(in_local_ready ? 1 : 0);
            end
        end
    end

    initial begin
        int pat4[4];
        int pat8[8];
        pat4 = '{1, 0, 0, 1};
        pat8 = '{1, 1, 1, 1, 0, 0, 0, 1};

        // Reset and idle.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1);

        // Single ring worm, full throughput.
        rq.push_back('{data: 16'h0005, last: 1'b0});
        rq.push_back('{data: 16'h00A1, last: 1'b0});
        rq.push_back('{data: 16'h00A2, last: 1'b1});
        for (int i = 0; i < 3; i++) cycle(1);
        check("single_done", rq.size(), 0);
        check_order("single_order", '{0});

        // Fairness under saturation.
        do_reset();
        for (int i = 0; i < 12; i++) add_pkt(0, 2, 16'h1000 + 16'(i * 16));
        for (int i = 0; i < 2; i++)  add_pkt(1, 2, 16'h2000 + 16'(i * 16));
        drain(200, 1);
        check_order("fair_order", '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1});

        // Local worm under backpressure, ring arrives one cycle later.
        do_reset();
        add_pkt(1, 4, 16'h0D00);
        add_pkt(0, 2, 16'h0E00);
        r_en = 1'b0;
        for (int i = 0; i < 14; i++) begin
            cycle(pat4[i % 4]);
            r_en = 1'b1;
        end
        drain(50, 1);
        check_order("atomic_order", '{1, 0});

        // Stalled single-flit local grant at counter saturation.
        do_reset();
        for (int i = 0; i < 6; i++) add_pkt(0, 1, 16'h3000 + 16'(i));
        add_pkt(1, 1, 16'h0C01);
        for (int i = 0; i < 8; i++) cycle(pat8[i]);
        drain(50, 1);
        check_order("stall_order", '{0, 0, 0, 0, 1, 0, 0});

        // Reset in the middle of a ring worm.
        do_reset();
        add_pkt(0, 4, 16'h4000);
        cycle(1);
        cycle(0);
        mon_en = 1'b0;
        rst_n = 1'b0;
        in_ring_valid  = 1'b0;
        in_local_valid = 1'b1;
        in_local_data  = 16'h0BEE;
        in_local_last  = 1'b1;
        out_ring_ready = 1'b1;
        #1;
        check("midrst_valid", out_ring_valid, 1);
        check("midrst_local_ready", in_local_ready, 1);
        check("midrst_ring_ready", in_ring_ready, 0);
        check("midrst_data", out_ring_data, 16'h0BEE);
        do_reset();
        add_pkt(1, 2, 16'h5000);
        drain(20, 1);
        check_order("midrst_order", '{1});

        // Randomized traffic.
        do_reset();
        pres_pct = 60; rdy_pct = 70;
        for (int i = 0; i < 30; i++) add_pkt(0, $urandom_range(4, 1), 16'($urandom));
        for (int i = 0; i < 20; i++) add_pkt(1, $urandom_range(4, 1), 16'($urandom));
        drain(3000, -1);

        do_reset();
        pres_pct = 90; rdy_pct = 90;
        for (int i = 0; i < 30; i++) add_pkt(0, $urandom_range(4, 1), 16'($urandom));
        for (int i = 0; i < 30; i++) add_pkt(1, $urandom_range(4, 1), 16'($urandom));
        drain(3000, -1);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
